// File: rtl/vga_timing_core_if.sv
// Pixel FIFO link between the upstream frame source and the VGA timing core.
// First-word-fall-through: pixel_in is valid whenever fifo_empty is low.
interface vga_timing_core_if #(
  parameter int COLOR_W = 8
);
  logic                   fifo_empty;
  logic [3*COLOR_W-1:0]   pixel_in;
  logic                   fifo_rd_en;

  modport master (
    output fifo_empty,
    output pixel_in,
    input  fifo_rd_en
  );

  modport slave (
    input  fifo_empty,
    input  pixel_in,
    output fifo_rd_en
  );
endinterface

// File: rtl/vga_timing_core.sv
// Parametrised VGA raster timing generator with registered pixel output stage.
// Waits in IDLE for the first pixel, then free-runs; flags FIFO underflow.
module vga_timing_core #(
  parameter int  H_ACTIVE = 640,
  parameter int  H_FP     = 16,
  parameter int  H_SYNC   = 96,
  parameter int  H_BP     = 48,
  parameter int  V_ACTIVE = 480,
  parameter int  V_FP     = 10,
  parameter int  V_SYNC   = 2,
  parameter int  V_BP     = 33,
  parameter bit  HS_POL   = 1'b0,
  parameter bit  VS_POL   = 1'b0,
  parameter int  COLOR_W  = 8,
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW       = $clog2(H_TOTAL),
  localparam int VW       = $clog2(V_TOTAL)
) (
  input  logic               clk,
  input  logic               rst,
  vga_timing_core_if.slave   fifo,
  input  logic               underflow_clr,
  output logic [COLOR_W-1:0] red,
  output logic [COLOR_W-1:0] green,
  output logic [COLOR_W-1:0] blue,
  output logic               hsync,
  output logic               vsync,
  output logic               comp_sync,
  output logic               blank_n,
  output logic [HW-1:0]      hcount,
  output logic [VW-1:0]      vcount,
  output logic               frame_start,
  output logic               underflow
);

  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state_q;
  logic [HW-1:0]        hcount_q;
  logic [VW-1:0]        vcount_q;
  logic [COLOR_W-1:0]   red_q, green_q, blue_q;
  logic [COLOR_W-1:0]   red_d, green_d, blue_d;
  logic                 hsync_q, vsync_q, comp_sync_q, blank_n_q;
  logic                 hsync_d, vsync_d, comp_sync_d;
  logic                 underflow_q, underflow_d;

  logic run, active, hs_on, vs_on, uf_evt;

  assign run    = (state_q == RUN);
  assign active = run
                & (32'(hcount_q) < H_ACTIVE)
                & (32'(vcount_q) < V_ACTIVE);
  assign hs_on  = (32'(hcount_q) >= HS_START)
                & (32'(hcount_q) <  HS_END);
  assign vs_on  = (32'(vcount_q) >= VS_START)
                & (32'(vcount_q) <  VS_END);
  assign uf_evt = active & fifo.fifo_empty;

  assign fifo.fifo_rd_en = active & ~fifo.fifo_empty;
  assign frame_start     = run & (hcount_q == '0) & (vcount_q == '0);

  assign red_d   = fifo.fifo_rd_en
                 ? fifo.pixel_in[3*COLOR_W-1 -: COLOR_W] : '0;
  assign green_d = fifo.fifo_rd_en
                 ? fifo.pixel_in[2*COLOR_W-1 -: COLOR_W] : '0;
  assign blue_d  = fifo.fifo_rd_en
                 ? fifo.pixel_in[COLOR_W-1 -: COLOR_W] : '0;

  assign hsync_d     = hs_on ? HS_POL : ~HS_POL;
  assign vsync_d     = vs_on ? VS_POL : ~VS_POL;
  assign comp_sync_d = ~(hs_on ^ vs_on);

  // a new underflow outranks a coincident clear
  assign underflow_d = uf_evt        ? 1'b1 :
                       underflow_clr ? 1'b0 : underflow_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      hcount_q    <= '0;
      vcount_q    <= '0;
      red_q       <= '0;
      green_q     <= '0;
      blue_q      <= '0;
      hsync_q     <= ~HS_POL;
      vsync_q     <= ~VS_POL;
      comp_sync_q <= 1'b1;
      blank_n_q   <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!fifo.fifo_empty) state_q <= RUN;
        end
        RUN: begin
          if (hcount_q == H_LAST) begin
            hcount_q <= '0;
            vcount_q <= (vcount_q == V_LAST) ? '0 : vcount_q + VW'(1);
          end else begin
            hcount_q <= hcount_q + HW'(1);
          end
          red_q       <= red_d;
          green_q     <= green_d;
          blue_q      <= blue_d;
          hsync_q     <= hsync_d;
          vsync_q     <= vsync_d;
          comp_sync_q <= comp_sync_d;
          blank_n_q   <= active;
          underflow_q <= underflow_d;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign red       = red_q;
  assign green     = green_q;
  assign blue      = blue_q;
  assign hsync     = hsync_q;
  assign vsync     = vsync_q;
  assign comp_sync = comp_sync_q;
  assign blank_n   = blank_n_q;
  assign hcount    = hcount_q;
  assign vcount    = vcount_q;
  assign underflow = underflow_q;

endmodule
